// File: rtl/s2c_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// s2c_pkg : function codes, return codes and FSM states for s2c_responder
// Revision 1.0
// ------------------------------------------------------------------
package s2c_pkg;

   localparam logic [31:0] FN_SETUP     = 32'd0;
   localparam logic [31:0] FN_CALL      = 32'd1;
   localparam logic [31:0] FN_CHECK_END = 32'd2;

   localparam logic signed [31:0] RET_OK        =  32'sd0;
   localparam logic signed [31:0] RET_ALREADY   =  32'sd1;
   localparam logic signed [31:0] RET_BAD_ID    = -32'sd1;
   localparam logic signed [31:0] RET_NOT_SETUP = -32'sd2;
   localparam logic signed [31:0] RET_BAD_FN    = -32'sd3;

   localparam int S2C_DATA_SIZE = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RESP   = 2'd1,
      ST_STREAM = 2'd2
   } s2c_state_e;

endpackage
`default_nettype wire

// File: rtl/s2c_data_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// s2c_data_buf : call-response data words, written from the load port
// Revision 1.0
// ------------------------------------------------------------------
module s2c_data_buf #(
   parameter int DATA_SIZE = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_wr_en,
   input  logic [3:0]  i_wr_addr,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_rd_idx,
   output logic [31:0] o_rd_data
);

   localparam logic [4:0] c_depth = 5'(DATA_SIZE);

   logic [31:0] r_mem [DATA_SIZE];
   logic        w_wr_hit;

   assign w_wr_hit = i_wr_en & ({1'b0, i_wr_addr} < c_depth);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DATA_SIZE; k++) begin
            r_mem[k] <= '0;
         end
      end else if (w_wr_hit) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = ({1'b0, i_rd_idx} < c_depth) ? r_mem[i_rd_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/s2c_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// s2c_responder : setup/call/check-end request handler with streamed call data
// Revision 1.0
// ------------------------------------------------------------------
module s2c_responder
   import s2c_pkg::*;
#(
   parameter int NUM_IDS   = 8,
   parameter int DATA_SIZE = S2C_DATA_SIZE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_id,
   input  logic [31:0]        req_fn,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_id,
   output logic signed [31:0] rsp_ret,
   output logic [31:0]        rsp_data,
   output logic [3:0]         rsp_idx,
   output logic               rsp_last,
   input  logic               ld_en,
   input  logic [3:0]         ld_addr,
   input  logic [31:0]        ld_data,
   output logic               ld_ready,
   input  logic               end_evt,
   output logic [15:0]        call_cnt
);

   localparam int          c_idw      = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
   localparam logic [3:0]  c_last_idx = 4'(DATA_SIZE - 1);
   localparam logic [31:0] c_num_ids  = 32'(NUM_IDS);

   s2c_state_e         r_state;
   logic [31:0]        r_id;
   logic signed [31:0] r_ret;
   logic [NUM_IDS-1:0] r_setup;
   logic               r_end_pending;
   logic [3:0]         r_idx;
   logic [15:0]        r_call_cnt;

   logic               w_idle;
   logic               w_req_acc;
   logic               w_beat;
   logic               w_last;
   logic               w_id_ok;
   logic [c_idw-1:0]   w_id_idx;
   logic [31:0]        w_buf_data;
   logic signed [31:0] w_ret;
   s2c_state_e         w_next;
   logic               w_set_bit;
   logic               w_check;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_req_acc = req_valid & w_idle;
   assign w_beat    = rsp_valid & rsp_ready;
   assign w_last    = (r_state == ST_STREAM) && (r_idx == c_last_idx);
   assign w_id_ok   = (req_id < c_num_ids);
   assign w_id_idx  = req_id[c_idw-1:0];

   // Request decode; only consumed on an accepting cycle
   always_comb begin
      w_ret     = RET_BAD_FN;
      w_next    = ST_RESP;
      w_set_bit = 1'b0;
      w_check   = 1'b0;
      case (req_fn)
         FN_SETUP: begin
            if (!w_id_ok) begin
               w_ret = RET_BAD_ID;
            end else if (r_setup[w_id_idx]) begin
               w_ret = RET_ALREADY;
            end else begin
               w_ret     = RET_OK;
               w_set_bit = 1'b1;
            end
         end
         FN_CALL: begin
            if (!w_id_ok) begin
               w_ret = RET_BAD_ID;
            end else if (!r_setup[w_id_idx]) begin
               w_ret = RET_NOT_SETUP;
            end else begin
               w_ret  = RET_OK;
               w_next = ST_STREAM;
            end
         end
         FN_CHECK_END: begin
            w_check = 1'b1;
            w_ret   = (r_end_pending | end_evt) ? 32'sd1 : 32'sd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_id       <= '0;
         r_ret      <= '0;
         r_idx      <= '0;
         r_call_cnt <= '0;
      end else if (w_req_acc) begin
         r_state <= w_next;
         r_id    <= req_id;
         r_ret   <= w_ret;
         r_idx   <= '0;
      end else if (w_beat) begin
         if ((r_state == ST_STREAM) && !w_last) begin
            r_idx <= r_idx + 4'd1;
         end else begin
            r_state <= ST_IDLE;
         end
         if (w_last) begin
            r_call_cnt <= r_call_cnt + 16'd1;
         end
      end
   end

   // A CHECK_END acceptance wins over a coincident end event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_setup       <= '0;
         r_end_pending <= 1'b0;
      end else begin
         if (w_req_acc && w_check) begin
            r_setup       <= '0;
            r_end_pending <= 1'b0;
         end else begin
            if (w_req_acc && w_set_bit) begin
               r_setup[w_id_idx] <= 1'b1;
            end
            if (end_evt) begin
               r_end_pending <= 1'b1;
            end
         end
      end
   end

   s2c_data_buf #(
      .DATA_SIZE (DATA_SIZE)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (ld_en & w_idle),
      .i_wr_addr (ld_addr),
      .i_wr_data (ld_data),
      .i_rd_idx  (r_idx),
      .o_rd_data (w_buf_data)
   );

   assign req_ready = w_idle;
   assign ld_ready  = w_idle;
   assign rsp_valid = !w_idle;
   assign rsp_id    = r_id;
   assign rsp_ret   = r_ret;
   assign rsp_idx   = r_idx;
   assign rsp_data  = (r_state == ST_STREAM) ? w_buf_data : '0;
   assign rsp_last  = (r_state == ST_RESP) | w_last;
   assign call_cnt  = r_call_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s2c_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_s2c_responder : directed table, corner sequences and random traffic
// Revision 1.0
// ------------------------------------------------------------------
module tb_s2c_responder;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               req_valid;
   logic               req_ready;
   logic [31:0]        req_id;
   logic [31:0]        req_fn;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_id;
   logic signed [31:0] rsp_ret;
   logic [31:0]        rsp_data;
   logic [3:0]         rsp_idx;
   logic               rsp_last;
   logic               ld_en;
   logic [3:0]         ld_addr;
   logic [31:0]        ld_data;
   logic               ld_ready;
   logic               end_evt;
   logic [15:0]        call_cnt;

   always #5 clk = ~clk;

   s2c_responder #(
      .NUM_IDS   (8),
      .DATA_SIZE (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_id    (req_id),
      .req_fn    (req_fn),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_ret   (rsp_ret),
      .rsp_data  (rsp_data),
      .rsp_idx   (rsp_idx),
      .rsp_last  (rsp_last),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .end_evt   (end_evt),
      .call_cnt  (call_cnt)
   );

   typedef struct packed {
      logic [31:0] id;
      logic [31:0] ret;
      logic [31:0] data;
      logic [3:0]  idx;
      logic        last;
   } beat_t;

   typedef struct {
      logic [31:0] fn;
      logic [31:0] id;
      int          ret;
      int          beats;
      int          cnt;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   beat_t       q_beats[$];
   vec_t        vecs[12];

   // Reference state: which ids are set up, pending end flag, buffer, call count
   bit          m_setup[8];
   bit          m_pend;
   logic [31:0] m_buf[16];
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_setup[i]) m_setup[i] = 1'b0;
      foreach (m_buf[i]) m_buf[i] = 32'd0;
      m_pend = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_req(input logic [31:0] fn, input logic [31:0] id, input bit evt,
                            output int ret, output int beats);
      beats = 1;
      ret   = -3;
      if (fn == 32'd0) begin
         if (id >= 32'd8)        ret = -1;
         else if (m_setup[id])   ret = 1;
         else begin m_setup[id] = 1'b1; ret = 0; end
      end else if (fn == 32'd1) begin
         if (id >= 32'd8)        ret = -1;
         else if (!m_setup[id])  ret = -2;
         else begin
            ret   = 0;
            beats = 16;
            m_cnt = (m_cnt + 1) & 16'hFFFF;
         end
      end else if (fn == 32'd2) begin
         ret    = (m_pend || evt) ? 1 : 0;
         m_pend = 1'b0;
         foreach (m_setup[i]) m_setup[i] = 1'b0;
      end
      if (evt && fn != 32'd2) m_pend = 1'b1;
   endtask

   task automatic ld_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      chk("ld_ready_idle", 32'(ld_ready), 32'd1);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
      m_buf[a] = d;
   endtask

   task automatic pulse_evt();
      @(negedge clk);
      end_evt = 1'b1;
      @(posedge clk); #1;
      end_evt = 1'b0;
      m_pend = 1'b1;
   endtask

   task automatic send_req(input logic [31:0] fn, input logic [31:0] id, input bit ld_co,
                           input logic [3:0] la, input logic [31:0] ldd, input bit evt);
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_fn = fn; req_id = id;
      ld_en = ld_co; ld_addr = la; ld_data = ldd;
      end_evt = evt;
      @(posedge clk); #1;
      req_valid = 1'b0; ld_en = 1'b0; end_evt = 1'b0;
   endtask

   // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
   task automatic collect(input int mode, input bit noise);
      beat_t cur, prev;
      bit    prev_stall = 1'b0;
      bit    r = 1'b0;
      bit    tgl = 1'b0;
      bit    done = 1'b0;
      prev = '0;
      q_beats.delete();
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         cur.id = rsp_id; cur.ret = rsp_ret; cur.data = rsp_data;
         cur.idx = rsp_idx; cur.last = rsp_last;
         chk("rsp_valid_busy", 32'(rsp_valid), 32'd1);
         if (!rsp_valid) break;
         if (prev_stall) begin
            checks++;
            if (cur !== prev) begin
               errors++;
               $display("FAIL stall_stable actual=%h required=%h", cur, prev);
            end
         end
         chk("req_ready_busy", 32'(req_ready), 32'd0);
         chk("ld_ready_busy", 32'(ld_ready), 32'd0);
         if (mode == 0)      r = 1'b1;
         else if (mode == 1) begin r = ~tgl; tgl = r; end
         else                r = 1'($urandom_range(0, 1));
         rsp_ready = r;
         if (noise) begin
            ld_en = 1'b1; ld_addr = 4'($urandom_range(0, 15)); ld_data = $urandom;
         end
         if (r) begin
            q_beats.push_back(cur);
            if (cur.last) done = 1'b1;
         end
         prev_stall = !r;
         prev = cur;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL resp_complete actual=%0d beats required=last beat", q_beats.size());
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0; ld_en = 1'b0;
   endtask

   task automatic do_txn(input logic [31:0] fn, input logic [31:0] id, input bit ld_co,
                         input logic [3:0] la, input logic [31:0] ldd, input bit evt,
                         input int mode, input bit noise, output int got_ret, output int got_beats);
      int eret, ebeats;
      if (ld_co) m_buf[la] = ldd;
      model_req(fn, id, evt, eret, ebeats);
      send_req(fn, id, ld_co, la, ldd, evt);
      collect(mode, noise);
      got_beats = q_beats.size();
      got_ret   = (got_beats > 0) ? int'(q_beats[0].ret) : 99;
      chk("beat_count", 32'(got_beats), 32'(ebeats));
      foreach (q_beats[k]) begin
         chk("beat_idx",  32'(q_beats[k].idx), 32'(k));
         chk("beat_data", q_beats[k].data, (ebeats == 16) ? m_buf[k] : 32'd0);
         chk("beat_last", 32'(q_beats[k].last), 32'(k == got_beats - 1));
         chk("beat_ret",  q_beats[k].ret, 32'(eret));
         chk("beat_id",   q_beats[k].id, id);
      end
      @(negedge clk);
      chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
      chk("call_cnt", 32'(call_cnt), 32'(m_cnt));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int  gr, gb;
      bit  fired;
      rst_n = 1'b0; req_valid = 1'b0; req_id = '0; req_fn = '0; rsp_ready = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; end_evt = 1'b0;
      model_reset();

      vecs[0]  = '{32'd0, 32'd3,          0,  1, 0};
      vecs[1]  = '{32'd0, 32'd3,          1,  1, 0};
      vecs[2]  = '{32'd0, 32'd8,         -1,  1, 0};
      vecs[3]  = '{32'd1, 32'd5,         -2,  1, 0};
      vecs[4]  = '{32'd7, 32'd3,         -3,  1, 0};
      vecs[5]  = '{32'd1, 32'd3,          0, 16, 1};
      vecs[6]  = '{32'd1, 32'd8,         -1,  1, 1};
      vecs[7]  = '{32'd0, 32'hFFFF_FFFF, -1,  1, 1};
      vecs[8]  = '{32'd0, 32'd7,          0,  1, 1};
      vecs[9]  = '{32'd1, 32'd7,          0, 16, 2};
      vecs[10] = '{32'd2, 32'd0,          0,  1, 2};
      vecs[11] = '{32'd1, 32'd3,         -2,  1, 2};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_ld_ready",  32'(ld_ready),  32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_ret",   rsp_ret,        32'd0);
      chk("rst_rsp_data",  rsp_data,       32'd0);
      chk("rst_rsp_idx",   32'(rsp_idx),   32'd0);
      chk("rst_rsp_last",  32'(rsp_last),  32'd0);
      chk("rst_rsp_id",    rsp_id,         32'd0);
      chk("rst_call_cnt",  32'(call_cnt),  32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 16; k++) ld_write(4'(k), 32'h100 + 32'(k));

      for (int i = 0; i < 12; i++) begin
         do_txn(vecs[i].fn, vecs[i].id, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
         chk("tbl_ret",   32'(gr), 32'(vecs[i].ret));
         chk("tbl_beats", 32'(gb), 32'(vecs[i].beats));
         chk("tbl_cnt",   32'(call_cnt), 32'(vecs[i].cnt));
         if (i == 5 && gb == 16) chk("tbl_data_15", q_beats[15].data, 32'h10F);
      end

      // Stalled stream with loads attempted while busy
      do_txn(32'd0, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      chk("stall_setup", 32'(gr), 32'd0);
      do_txn(32'd1, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0, 1, 1'b1, gr, gb);
      chk("stall_ret", 32'(gr), 32'd0);
      chk("stall_beats", 32'(gb), 32'd16);
      chk("stall_cnt", 32'(call_cnt), 32'd3);

      // End event ahead of CHECK_END, then coincident with it
      pulse_evt();
      do_txn(32'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      chk("end_first", 32'(gr), 32'd1);
      do_txn(32'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      chk("end_second", 32'(gr), 32'd0);
      do_txn(32'd1, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      chk("end_setup_clr", 32'(gr), 32'hFFFF_FFFE);
      do_txn(32'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 0, 1'b0, gr, gb);
      chk("end_coincident", 32'(gr), 32'd1);
      do_txn(32'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      chk("end_after_coinc", 32'(gr), 32'd0);

      // Reset while beat 5 of a stream is on the bus
      do_txn(32'd0, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      send_req(32'd1, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0);
      rsp_ready = 1'b1;
      fired = 1'b0;
      for (int cyc = 0; cyc < 60 && !fired; cyc++) begin
         @(negedge clk);
         if (rsp_valid && rsp_idx == 4'd5) begin
            rst_n = 1'b0;
            #1;
            chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("abort_call_cnt",  32'(call_cnt),  32'd0);
            chk("abort_req_ready", 32'(req_ready), 32'd1);
            chk("abort_rsp_last",  32'(rsp_last),  32'd0);
            fired = 1'b1;
         end
      end
      if (!fired) begin
         checks++; errors++;
         $display("FAIL abort_beat5 actual=not seen required=beat 5");
      end
      rsp_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_cnt",   32'(call_cnt),  32'd0);
      do_txn(32'd0, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);
      chk("post_rst_setup", 32'(gr), 32'd0);
      do_txn(32'd1, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0, 0, 1'b0, gr, gb);

      // Random traffic against the reference model
      for (int it = 0; it < 60; it++) begin
         logic [31:0] fn, id;
         int          sel;
         repeat ($urandom_range(0, 2)) ld_write(4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 5) == 0) pulse_evt();
         sel = $urandom_range(0, 9);
         if (sel < 3)      fn = 32'd0;
         else if (sel < 6) fn = 32'd1;
         else if (sel < 8) fn = 32'd2;
         else              fn = 32'd3 + 32'($urandom_range(0, 1000));
         id = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 10));
         do_txn(fn, id, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 5) == 0), 2, 1'($urandom_range(0, 1)), gr, gb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/s2c_responder.md
S2C_RESPONDER -- requirements
Module: s2c_responder

Interface
REQ-001 SHALL have parameter NUM_IDS, default 8, number of function ids served (1..32).
REQ-002 SHALL have parameter DATA_SIZE, default 16, data words per call response (1..16).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have request ports: req_valid in 1, req_ready out 1, req_id in 32, req_fn in 32.
REQ-006 SHALL have response ports: rsp_valid out 1, rsp_ready in 1, rsp_id out 32, rsp_ret out 32 (signed), rsp_data out 32, rsp_idx out 4, rsp_last out 1.
REQ-007 SHALL have load ports: ld_en in 1, ld_addr in 4, ld_data in 32, ld_ready out 1.
REQ-008 SHALL have end_evt in 1 (end-event pulse) and call_cnt out 16 (successful calls).

Function
REQ-009 SHALL implement states IDLE, RESP (single beat), STREAM (DATA_SIZE beats).
REQ-010 SHALL drive req_ready=1 and ld_ready=1 only in IDLE.
REQ-011 SHALL accept a request on req_valid&req_ready, latch id/fn, and assert rsp_valid the next cycle.
REQ-012 SHALL hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-013 SHALL complete a beat on rsp_valid&rsp_ready; return to IDLE after the beat with rsp_last=1.
REQ-014 fn=0 (SETUP): id>=NUM_IDS -> ret -1; id already set up -> ret 1; else set setup bit, ret 0; RESP.
REQ-015 fn=1 (CALL): id>=NUM_IDS -> ret -1, RESP; setup bit clear -> ret -2, RESP; else ret 0, STREAM.
REQ-016 fn=2 (CHECK_END): ret = (end_pending|end_evt) ? 1 : 0; clear end_pending and all setup bits; RESP.
REQ-017 Any other fn SHALL return ret -3 in RESP with no state side effect.
REQ-018 In RESP: rsp_data=0, rsp_idx=0, rsp_last=1.
REQ-019 In STREAM: beat k drives rsp_idx=k, rsp_data=buf[k], rsp_last=(k==DATA_SIZE-1); rsp_ret and rsp_id constant.
REQ-020 call_cnt SHALL increment (wrapping 0xFFFF->0) on the last STREAM beat handshake.
REQ-021 end_pending SHALL set on end_evt in any state; a CHECK_END acceptance coincident with end_evt reports 1 and leaves end_pending clear.
REQ-022 ld_en&ld_ready SHALL write buf[ld_addr]; ld_addr>=DATA_SIZE ignored; ld_en outside IDLE ignored.
REQ-023 A load and a request in the same IDLE cycle SHALL both take effect; the load is visible to that CALL's stream.
REQ-024 rsp_id SHALL echo the latched req_id for every beat.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, req_ready=1, ld_ready=1, rsp_valid=0, rsp_ret=0, rsp_data=0, rsp_idx=0, rsp_last=0, rsp_id=0, call_cnt=0, setup bits=0, end_pending=0, buf=0.
REQ-026 Reset mid-STREAM SHALL abort the response with no further beats; call_cnt not incremented.
REQ-027 Deassertion SHALL take effect at the next clk edge; first request accepted no earlier than that cycle.

Structure
REQ-028 Package s2c_pkg SHALL hold FN_SETUP=0, FN_CALL=1, FN_CHECK_END=2, RET_OK=0, RET_ALREADY=1, RET_BAD_ID=-1, RET_NOT_SETUP=-2, RET_BAD_FN=-3, S2C_DATA_SIZE=16, and the state enum.
REQ-029 The data buffer with load port and read index SHALL be sub-module s2c_data_buf; everything else in s2c_responder.

Verification
REQ-030 Load buf[k]=0x100+k (k=0..15), SETUP id=3 -> ret 0; CALL id=3 -> 16 beats, data 0x100..0x10F, last on idx 15, call_cnt=1.
REQ-031 SETUP id=3 twice -> ret 0 then 1; SETUP id=8 -> ret -1; CALL id=5 (not set up) -> ret -2; fn=7 -> ret -3.
REQ-032 CALL id=3 with rsp_ready toggling 1/0 every cycle -> all 16 beats delivered in order, outputs stable while stalled, req_ready=0 throughout.
REQ-033 end_evt pulse, then CHECK_END -> ret 1; CHECK_END again -> ret 0; CALL id=3 -> ret -2 (setup cleared).
REQ-034 CHECK_END accepted in same cycle as end_evt -> ret 1; following CHECK_END -> ret 0.
REQ-035 rst_n low at beat 5 of CALL -> rsp_valid=0 immediately, call_cnt=0; after release SETUP id=3 -> ret 0.
